fetch_unit: RTL and testbench

- Instruction-fetch stage; produces the instrf/pcf/pc4f triple consumed by the IF/ID pipeline register.
- Owns the architectural PC and runs a single-outstanding request/grant/response handshake to instruction memory.
- Holds the fetched instruction while the hazard unit stalls.
- Applies branch/jump redirects from execute, discarding any wrong-path response already in flight.

---
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory and presents instrf/pcf/pc4f to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        validf,
    output logic [31:0] instrf,
    output logic [31:0] pcf,
    output logic [31:0] pc4f,
    output logic        dbg_state
);

    // Handshake: a request transfers on a cycle with imem_req=1 and imem_gnt=1;
    // exactly one imem_rvalid pulse follows each transfer, at least a cycle later.
    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        kill;
    logic        consume;
    logic        granted;

    assign consume   = validf && !stall;
    // Only issue when the output register is free, since memory cannot be back-pressured.
    assign imem_req  = rst_n && (state == S_REQ) && (!validf || !stall) && !redirect;
    assign imem_addr = pc;
    assign granted   = imem_req && imem_gnt;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            kill   <= 1'b0;
            validf <= 1'b0;
            instrf <= 32'h0;
            pcf    <= 32'h0;
            pc4f   <= 32'h0;
        end else if (redirect) begin
            // Redirect beats stall and capture; any in-flight response is wrong-path.
            pc     <= {redirect_pc[31:2], 2'b00};
            validf <= 1'b0;
            if (state == S_WAIT) begin
                if (imem_rvalid) begin
                    kill  <= 1'b0;
                    state <= S_REQ;
                end else begin
                    kill <= 1'b1;
                end
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (granted) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        kill   <= 1'b0;
                        state  <= S_WAIT;
                    end
                    if (consume) begin
                        validf <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                        kill  <= 1'b0;
                    end
                    if (imem_rvalid && !kill) begin
                        instrf <= imem_rdata;
                        pcf    <= req_pc;
                        pc4f   <= req_pc + 32'd4;
                        validf <= 1'b1;
                    end else if (consume) begin
                        validf <= 1'b0;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through reset, wait states, stall, redirect
// and PC wrap, then randomized traffic against a transaction-level model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        validf;
    logic [31:0] instrf;
    logic [31:0] pcf;
    logic [31:0] pc4f;
    logic        dbg_state;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .validf(validf), .instrf(instrf), .pcf(pcf), .pc4f(pc4f), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    // architectural view of the fetch stage
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_busy;
    logic        m_wrong;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcf;
    logic [31:0] m_pc4;
    logic        e_req;

    // memory side
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          cur_dly;
    logic        seen_req;
    logic [31:0] seen_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        if (a == 32'h0000_0108) return 32'hDEAD_BEEF;
        return a * 32'h0001_0001 + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then compare against the model.
    task automatic apply(input logic s, input logic r, input logic [31:0] rp,
                         input logic g, input int dly);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_gnt    = g;
        cur_dly     = dly;
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
        #1;
        n_vec++;
        e_req = !m_busy && (!m_valid || !s) && !r;
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("validf", {31'b0, validf}, {31'b0, m_valid});
        chk("instrf", instrf, m_instr);
        chk("pcf", pcf, m_pcf);
        chk("pc4f", pc4f, m_pc4);
        seen_req  = imem_req;
        seen_addr = imem_addr;
    endtask

    // Rising edge: advance model and memory using the values driven in apply.
    task automatic tick();
        logic granted;
        logic consume;
        @(posedge clk);
        granted = e_req && imem_gnt;
        consume = m_valid && !stall;
        if (redirect) begin
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_valid = 1'b0;
            if (m_busy) begin
                if (imem_rvalid) begin
                    m_busy  = 1'b0;
                    m_wrong = 1'b0;
                end else begin
                    m_wrong = 1'b1;
                end
            end
        end else if (m_busy && imem_rvalid) begin
            m_busy = 1'b0;
            if (m_wrong) begin
                m_wrong = 1'b0;
                if (consume) m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_instr = imem_rdata;
                m_pcf   = m_req_pc;
                m_pc4   = m_req_pc + 32'd4;
            end
        end else begin
            if (granted) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_busy   = 1'b1;
                m_wrong  = 1'b0;
            end
            if (consume) m_valid = 1'b0;
        end
        if (imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (seen_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_addr = seen_addr;
            mem_cnt  = cur_dly;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        m_pc = 32'h100; m_req_pc = 32'h100; m_busy = 1'b0; m_wrong = 1'b0;
        m_valid = 1'b0; m_instr = 32'h0; m_pcf = 32'h0; m_pc4 = 32'h0; e_req = 1'b0;
        mem_pend = 1'b0; mem_addr = 32'h0; mem_cnt = 0; cur_dly = 0;
        seen_req = 1'b0; seen_addr = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst validf", {31'b0, validf}, 32'h0);
        chk("rst pcf", pcf, 32'h0);
        chk("rst pc4f", pc4f, 32'h0);
        rst_n = 1'b1;

        // first fetch after reset
        apply(0, 0, 0, 1, 0);
        chk("first addr", imem_addr, 32'h100);
        chk("first req", {31'b0, imem_req}, 32'h1);
        tick();
        apply(0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        chk("first instrf", instrf, 32'h0050_0093);
        chk("first pcf", pcf, 32'h100);
        chk("first pc4f", pc4f, 32'h104);
        chk("first validf", {31'b0, validf}, 32'h1);
        chk("next addr", imem_addr, 32'h104);
        tick();

        // memory wait states
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0);
            chk("held req", {31'b0, imem_req}, 32'h1);
            chk("held addr", imem_addr, 32'h104);
            tick();
        end
        apply(0, 0, 0, 1, 3);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 0);
            chk("wait no req", {31'b0, imem_req}, 32'h0);
            tick();
        end

        // stall holds the output and blocks requests
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 1, 0);
            chk("stall req", {31'b0, imem_req}, 32'h0);
            chk("stall pcf", pcf, 32'h104);
            chk("stall pc4f", pc4f, 32'h108);
            chk("stall validf", {31'b0, validf}, 32'h1);
            tick();
        end
        apply(0, 0, 0, 1, 2);
        chk("unstall req", {31'b0, imem_req}, 32'h1);
        chk("unstall addr", imem_addr, 32'h108);
        tick();

        // redirect while waiting: wrong-path response dropped
        apply(0, 1, 32'h2003, 1, 0);
        chk("redir req", {31'b0, imem_req}, 32'h0);
        tick();
        apply(0, 0, 0, 1, 0);
        chk("redir validf", {31'b0, validf}, 32'h0);
        tick();
        apply(0, 0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 1, 0);
        chk("killed validf", {31'b0, validf}, 32'h0);
        chk("killed instrf", instrf, 32'h0104_0117);
        chk("redir addr", imem_addr, 32'h2000);
        tick();

        // redirect coincident with rvalid under stall
        apply(1, 1, 32'hFFFF_FFFC, 1, 0);
        tick();
        apply(0, 0, 0, 1, 1);
        chk("drop validf", {31'b0, validf}, 32'h0);
        chk("drop pcf", pcf, 32'h104);
        chk("top addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        apply(0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        tick();

        // PC wrap
        apply(1, 0, 0, 0, 0);
        chk("wrap pcf", pcf, 32'hFFFF_FFFC);
        chk("wrap pc4f", pc4f, 32'h0);
        chk("wrap addr", imem_addr, 32'h0);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            apply($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rp,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
